// File: rtl/seg_display_capture.sv
`default_nettype none
// ============================================================================
//  Module      : seg_display_capture
//  Description : Monitors a multiplexed active-low 4-digit seven-segment bus,
//                decodes each settled digit back to BCD and publishes
//                complete 16-bit frames with per-digit decimal points.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_display_capture #(
    parameter int SETTLE      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  seg_an,
    input  logic [7:0]  seg_cat,
    output logic [15:0] bcd,
    output logic [3:0]  dp,
    output logic        frame_valid,
    output logic [3:0]  digit_mask,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    // Threshold widened to 9 bits so the compare against count+1 never overflows
    localparam logic [8:0] SETTLE_W = 9'(SETTLE);
    // With a threshold of one the first sample already qualifies
    localparam state_t     FIRST_ST = (SETTLE <= 1) ? ST_CAPTURE : ST_SETTLE;

    logic [11:0] sync_q [SYNC_STAGES];
    logic [11:0] sample;
    logic [3:0]  samp_an;

    state_t      state, state_d;
    logic [11:0] lat;
    logic [7:0]  cnt;
    logic [15:0] stage_bcd;
    logic [3:0]  stage_dp;

    logic        an_idle, an_single, an_illegal;
    logic [1:0]  lat_idx;
    logic        dec_ok;
    logic [3:0]  dec_val;
    logic [6:0]  lat_seg;
    logic        lat_load, cnt_inc, do_capture;
    logic        cap_ok;
    logic [3:0]  mask_d;

    assign sample  = sync_q[SYNC_STAGES-1];
    assign samp_an = sample[11:8];
    assign lat_seg = ~lat[6:0];

    // Input synchronizer chain; resets to the idle (all ones) bus level
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
        end else begin
            sync_q[0] <= {seg_an, seg_cat};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Classify the synchronized anode field
    always_comb begin
        an_idle   = (samp_an == 4'hF);
        an_single = 1'b0;
        case (samp_an)
            4'hE, 4'hD, 4'hB, 4'h7: an_single = 1'b1;
            default:                an_single = 1'b0;
        endcase
        an_illegal = !an_idle && !an_single;
    end

    // Digit index of the latched anode (latched value is always a legal single)
    always_comb begin
        lat_idx = 2'd0;
        case (lat[11:8])
            4'hE:    lat_idx = 2'd0;
            4'hD:    lat_idx = 2'd1;
            4'hB:    lat_idx = 2'd2;
            4'h7:    lat_idx = 2'd3;
            default: lat_idx = 2'd0;
        endcase
    end

    // Segment pattern back to BCD; dash maps to 4'hF
    always_comb begin
        dec_ok  = 1'b1;
        dec_val = 4'h0;
        case (lat_seg)
            7'h3F:   dec_val = 4'h0;
            7'h06:   dec_val = 4'h1;
            7'h5B:   dec_val = 4'h2;
            7'h4F:   dec_val = 4'h3;
            7'h66:   dec_val = 4'h4;
            7'h6D:   dec_val = 4'h5;
            7'h7D:   dec_val = 4'h6;
            7'h27:   dec_val = 4'h7;
            7'h7F:   dec_val = 4'h8;
            7'h67:   dec_val = 4'h9;
            7'h40:   dec_val = 4'hF;
            default: dec_ok  = 1'b0;
        endcase
    end

    // Next-state logic: settle qualification, one-shot capture, hold until change
    always_comb begin
        state_d    = state;
        lat_load   = 1'b0;
        cnt_inc    = 1'b0;
        do_capture = 1'b0;
        case (state)
            ST_IDLE: begin
                if (an_single) begin
                    lat_load = 1'b1;
                    state_d  = FIRST_ST;
                end
            end
            ST_SETTLE: begin
                if (sample == lat) begin
                    cnt_inc = 1'b1;
                    if (({1'b0, cnt} + 9'd1) >= SETTLE_W) state_d = ST_CAPTURE;
                end else if (an_single) begin
                    lat_load = 1'b1;
                    state_d  = FIRST_ST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                do_capture = 1'b1;
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (sample != lat) begin
                    if (an_single) begin
                        lat_load = 1'b1;
                        state_d  = FIRST_ST;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Mask clears on frame completion; a capture in the same cycle survives
    always_comb begin
        cap_ok = do_capture && dec_ok;
        mask_d = (digit_mask == 4'hF) ? 4'h0 : digit_mask;
        if (cap_ok) mask_d[lat_idx] = 1'b1;
    end

    // FSM state, latch and saturating settle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            lat   <= '1;
            cnt   <= 8'd0;
        end else begin
            state <= state_d;
            if (lat_load) begin
                lat <= sample;
                cnt <= 8'd1;
            end else if (cnt_inc && (cnt != 8'hFF)) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // Staging, frame publication and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_bcd   <= 16'h0000;
            stage_dp    <= 4'h0;
            digit_mask  <= 4'h0;
            bcd         <= 16'h0000;
            dp          <= 4'h0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            digit_mask  <= mask_d;
            if (cap_ok) begin
                stage_bcd[{lat_idx, 2'b00} +: 4] <= dec_val;
                stage_dp[lat_idx]                <= ~lat[7];
            end
            if (digit_mask == 4'hF) begin
                bcd         <= stage_bcd;
                dp          <= stage_dp;
                frame_valid <= 1'b1;
            end
            if (an_illegal || (do_capture && !dec_ok)) err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_display_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_display_capture
//  Description : Directed self-checking bench for seg_display_capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  seg_an;
    logic [7:0]  seg_cat;
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic        frame_valid;
    logic [3:0]  digit_mask;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    int fv_cnt   = 0;
    int m1_cnt   = 0;
    int fv_base;
    int m1_base;

    seg_display_capture #(.SETTLE(4), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_an      (seg_an),
        .seg_cat     (seg_cat),
        .bcd         (bcd),
        .dp          (dp),
        .frame_valid (frame_valid),
        .digit_mask  (digit_mask),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Count frame pulses and cycles with digit 1 captured, sampled mid-cycle
    always @(negedge clk) begin
        if (frame_valid)   fv_cnt <= fv_cnt + 1;
        if (digit_mask[1]) m1_cnt <= m1_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h27;
            8: return 7'h7F;  9: return 7'h67;  default: return 7'h40;
        endcase
    endfunction

    function automatic logic [7:0] mkcat(input logic [6:0] s, input logic dp_lit);
        return ~{dp_lit, s};
    endfunction

    function automatic logic [3:0] an_of(input int k);
        case (k)
            0: return 4'hE;  1: return 4'hD;  2: return 4'hB;  default: return 4'h7;
        endcase
    endfunction

    task automatic drive(input logic [3:0] a, input logic [7:0] c, input int n);
        seg_an  = a;
        seg_cat = c;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic digit(input int k, input int val, input logic dp_lit);
        drive(an_of(k), mkcat(seg7(val), dp_lit), 10);
    endtask

    task automatic idle(input int n);
        drive(4'hF, 8'hFF, n);
    endtask

    initial begin
        rst = 1'b1;
        seg_an = 4'hF;
        seg_cat = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_bcd",  32'(bcd), 32'h0);
        check_eq("rst_dp",   32'(dp), 32'h0);
        check_eq("rst_fv",   32'(frame_valid), 32'h0);
        check_eq("rst_mask", 32'(digit_mask), 32'h0);
        check_eq("rst_err",  32'(err), 32'h0);
        rst = 1'b0;
        idle(3);

        // Basic frame 4321
        fv_base = fv_cnt;
        digit(0, 1, 1'b0); digit(1, 2, 1'b0); digit(2, 3, 1'b0); digit(3, 4, 1'b0);
        idle(4);
        check_eq("f1_count", 32'(fv_cnt - fv_base), 32'd1);
        check_eq("f1_bcd",   32'(bcd), 32'h4321);
        check_eq("f1_dp",    32'(dp), 32'h0);
        check_eq("f1_err",   32'(err), 32'h0);
        check_eq("f1_mask",  32'(digit_mask), 32'h0);

        // Dash with decimal point on digit 3
        fv_base = fv_cnt;
        digit(0, 1, 1'b0); digit(1, 2, 1'b0); digit(2, 3, 1'b0); digit(3, 15, 1'b1);
        idle(4);
        check_eq("f2_count", 32'(fv_cnt - fv_base), 32'd1);
        check_eq("f2_bcd",   32'(bcd), 32'hF321);
        check_eq("f2_dp",    32'(dp), 32'h8);

        // Unsettled digit 1 never captures, then a stable 0 does
        fv_base = fv_cnt;
        digit(0, 5, 1'b0);
        m1_base = m1_cnt;
        for (int i = 0; i < 10; i++)
            drive(4'hD, mkcat(seg7((i % 2 == 0) ? 1 : 2), 1'b0), 2);
        check_eq("tog_m1",    32'(m1_cnt - m1_base), 32'd0);
        check_eq("tog_mask",  32'(digit_mask), 32'h1);
        check_eq("tog_count", 32'(fv_cnt - fv_base), 32'd0);
        drive(4'hD, mkcat(seg7(0), 1'b0), 6);
        digit(2, 7, 1'b0);
        check_eq("tog_mask2", 32'(digit_mask), 32'h7);
        digit(3, 9, 1'b0);
        idle(4);
        check_eq("tog_fcount", 32'(fv_cnt - fv_base), 32'd1);
        check_eq("tog_bcd",    32'(bcd), 32'h9705);
        check_eq("tog_err",    32'(err), 32'h0);

        // Illegal anode sets sticky err
        drive(4'hC, 8'hF9, 1);
        idle(4);
        check_eq("ill_err", 32'(err), 32'h1);
        fv_base = fv_cnt;
        digit(0, 3, 1'b0); digit(1, 1, 1'b0); digit(2, 4, 1'b0); digit(3, 1, 1'b0);
        idle(4);
        check_eq("ill_fcount", 32'(fv_cnt - fv_base), 32'd1);
        check_eq("ill_bcd",    32'(bcd), 32'h1413);
        check_eq("ill_err2",   32'(err), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("ill_errclr", 32'(err), 32'h0);
        idle(3);

        // Undecodable pattern on digit 2
        fv_base = fv_cnt;
        digit(0, 8, 1'b0); digit(1, 6, 1'b0);
        drive(4'hB, mkcat(7'h01, 1'b0), 10);
        check_eq("und_err",  32'(err), 32'h1);
        check_eq("und_mask", 32'(digit_mask), 32'h3);
        digit(3, 2, 1'b0);
        check_eq("und_mask2",  32'(digit_mask), 32'hB);
        check_eq("und_count0", 32'(fv_cnt - fv_base), 32'd0);
        digit(2, 5, 1'b0);
        idle(4);
        check_eq("und_count1", 32'(fv_cnt - fv_base), 32'd1);
        check_eq("und_bcd",    32'(bcd), 32'h2568);

        // Reset mid-frame
        digit(0, 1, 1'b0); digit(1, 2, 1'b0); digit(2, 3, 1'b0);
        check_eq("mid_mask", 32'(digit_mask), 32'h7);
        seg_an = 4'hF; seg_cat = 8'hFF;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("mid_bcd",  32'(bcd), 32'h0);
        check_eq("mid_dp",   32'(dp), 32'h0);
        check_eq("mid_mask0", 32'(digit_mask), 32'h0);
        check_eq("mid_err",  32'(err), 32'h0);
        check_eq("mid_fv",   32'(frame_valid), 32'h0);
        idle(3);
        fv_base = fv_cnt;
        digit(0, 7, 1'b0); digit(1, 8, 1'b1); digit(2, 9, 1'b0); digit(3, 0, 1'b0);
        idle(4);
        check_eq("mid_fcount", 32'(fv_cnt - fv_base), 32'd1);
        check_eq("mid_bcd2",   32'(bcd), 32'h0987);
        check_eq("mid_dp2",    32'(dp), 32'h2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
